// File: rtl/psum_col_drain.sv
// Per-column partial-sum FIFOs drained as complete, column-aligned rows.
// A row pops only when every lane holds at least one entry.
module psum_col_drain #(
   parameter int col     = 8,
   parameter int bw_psum = 20,
   parameter int depth   = 8,
   parameter int ptr_bw  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         fifo_wr,
   input  logic [bw_psum*col-1:0] in_data,
   input  logic                   flush,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [bw_psum*col-1:0] out_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   overflow
);

   localparam logic [ptr_bw:0] full_cnt = (ptr_bw+1)'(depth);

   logic [bw_psum-1:0] mem [col][depth];
   logic [ptr_bw-1:0]  wptr [col];
   logic [ptr_bw-1:0]  rptr [col];
   logic [ptr_bw:0]    count [col];
   logic [col-1:0]     lane_full;
   logic [col-1:0]     lane_empty;
   logic [col-1:0]     wr_ok;
   logic               pop;

   // Accept/drop and pop are both decided on the pre-edge counts.
   always_comb begin
      lane_full  = '0;
      lane_empty = '0;
      for (int i = 0; i < col; i++) begin
         lane_full[i]  = (count[i] == full_cnt);
         lane_empty[i] = (count[i] == '0);
      end
      wr_ok = fifo_wr & ~lane_full & {col{~flush}};
      pop   = ~(|lane_empty) && (!out_valid || out_ready) && !flush;
   end

   assign o_full  = |lane_full;
   assign o_empty = (&lane_empty) && !out_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < col; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            count[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < col; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < col; i++) begin
            if (wr_ok[i])
               wptr[i] <= wptr[i] + 1'b1;
            if (pop)
               rptr[i] <= rptr[i] + 1'b1;
            if (wr_ok[i] && !pop)
               count[i] <= count[i] + 1'b1;
            else if (!wr_ok[i] && pop)
               count[i] <= count[i] - 1'b1;
         end
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (wr_ok[i])
            mem[i][wptr[i]] <= in_data[i*bw_psum +: bw_psum];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (!flush && |(fifo_wr & lane_full))
            overflow <= 1'b1;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (pop) begin
            out_valid <= 1'b1;
            for (int i = 0; i < col; i++)
               out_data[i*bw_psum +: bw_psum] <= mem[i][rptr[i]];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_psum_col_drain.sv
// Scenario-driven bench for psum_col_drain; every accepted row is checked
// against a scoreboard queue filled when the row's writes are driven.
module tb_psum_col_drain;

   localparam int COL   = 8;
   localparam int BW    = 20;
   localparam int DEPTH = 8;
   localparam int PB    = 3;
   localparam int W     = BW * COL;

   logic           clk = 1'b0;
   logic           reset;
   logic [COL-1:0] fifo_wr;
   logic [W-1:0]   in_data;
   logic           flush;
   logic           out_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           o_full;
   logic           o_empty;
   logic           overflow;

   logic [W-1:0]   sb [$];
   int             checks = 0;
   int             errors = 0;

   always #5 clk = ~clk;

   psum_col_drain #(
      .col(COL), .bw_psum(BW), .depth(DEPTH), .ptr_bw(PB)
   ) dut (
      .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .in_data(in_data),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .o_full(o_full), .o_empty(o_empty),
      .overflow(overflow)
   );

   function automatic logic [W-1:0] make_row(input int base);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < COL; i++)
         r[i*BW +: BW] = BW'(base + i);
      return r;
   endfunction

   // Transfers happen at the next rising edge; sample them mid-cycle.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         logic [W-1:0] exp_row;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_unexpected: got %h expected no row", out_data);
         end else begin
            exp_row = sb.pop_front();
            if (out_data !== exp_row) begin
               errors++;
               $display("[TB] FAIL scoreboard_row: got %h expected %h", out_data, exp_row);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fifo_wr = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", o_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_single_row();
      out_ready = 1'b1;
      in_data   = make_row(1);
      fifo_wr   = '1;
      sb.push_back(make_row(1));
      tick();
      fifo_wr = '0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass: got %b expected 0", out_valid); end
      checks++; if (o_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_not_empty: got %b expected 0", o_empty); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== make_row(1)) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", out_data, make_row(1)); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_clear: got %b expected 0", out_valid); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty: got %b expected 1", o_empty); end
   endtask

   task automatic test_staggered();
      out_ready = 1'b1;
      in_data   = '1;
      fifo_wr   = 8'h01;
      tick();
      fifo_wr = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stagger_wait%0d: got %b expected 0", c, out_valid); end
      end
      fifo_wr = 8'hFE;
      sb.push_back('1);
      tick();
      fifo_wr = '0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stagger_latency: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stagger_valid: got %b expected 1", out_valid); end
      checks++; if (out_data[BW-1:0] !== 20'hFFFFF) begin errors++; $display("[TB] FAIL stagger_lane0: got %h expected fffff", out_data[BW-1:0]); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stagger_clear: got %b expected 0", out_valid); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_data = make_row(256 + k*8);
         fifo_wr = '1;
         sb.push_back(make_row(256 + k*8));
         tick();
         checks++; if (out_valid !== (k >= 1)) begin errors++; $display("[TB] FAIL stream_valid%0d: got %b expected %b", k, out_valid, (k >= 1)); end
         checks++; if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL stream_full%0d: got %b expected 0", k, o_full); end
      end
      fifo_wr = '0;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_last: got %b expected 1", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end: got %b expected 0", out_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_overflow: got %b expected 0", overflow); end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL stream_drained: got %0d expected 0", sb.size()); end
   endtask

   // Row 1 moves to out_data on the second edge, so eight more fit and the tenth drops.
   task automatic test_overflow();
      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         in_data = make_row(k*16);
         fifo_wr = '1;
         if (k <= 9)
            sb.push_back(make_row(k*16));
         tick();
         checks++; if (o_full !== (k >= 9)) begin errors++; $display("[TB] FAIL ovf_full%0d: got %b expected %b", k, o_full, (k >= 9)); end
         checks++; if (overflow !== (k >= 10)) begin errors++; $display("[TB] FAIL ovf_flag%0d: got %b expected %b", k, overflow, (k >= 10)); end
      end
      fifo_wr = '0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_hold_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== make_row(16)) begin errors++; $display("[TB] FAIL ovf_hold_data: got %h expected %h", out_data, make_row(16)); end
      out_ready = 1'b1;
      repeat (9) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_valid: got %b expected 0", out_valid); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drain_empty: got %b expected 1", o_empty); end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL ovf_drained: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_data = make_row(32'h500 + k*8);
         fifo_wr = '1;
         tick();
      end
      flush   = 1'b1;
      in_data = make_row(32'h700);
      tick();
      flush   = 1'b0;
      fifo_wr = '0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %b expected 1", o_empty); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL flush_overflow: got %b expected 1", overflow); end
      out_ready = 1'b1;
      in_data   = make_row(32'h900);
      fifo_wr   = '1;
      sb.push_back(make_row(32'h900));
      tick();
      fifo_wr = '0;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_new_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== make_row(32'h900)) begin errors++; $display("[TB] FAIL flush_new_data: got %h expected %h", out_data, make_row(32'h900)); end
      tick();
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_end_empty: got %b expected 1", o_empty); end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL flush_drained: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_data = make_row(32'hB00 + k*8);
         fifo_wr = '1;
         tick();
      end
      fifo_wr = '0;
      #2 reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL areset_data: got %h expected 0", out_data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL areset_overflow: got %b expected 0", overflow); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL areset_empty: got %b expected 1", o_empty); end
      tick();
      #2 reset = 1'b1;
      in_data   = make_row(32'hA00);
      fifo_wr   = '1;
      out_ready = 1'b1;
      sb.push_back(make_row(32'hA00));
      tick();
      fifo_wr = '0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_first_edge: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_row_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== make_row(32'hA00)) begin errors++; $display("[TB] FAIL areset_row_data: got %h expected %h", out_data, make_row(32'hA00)); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_end: got %b expected 0", out_valid); end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL areset_drained: got %0d expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_staggered();
      test_stream();
      test_overflow();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
